// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: responder for menu/RTC accesses, runs one muxed
// address/data bus cycle per Acceso, with a two-write init after reset.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   Acceso/Mod/Dir    request strobe, 1=write/0=read, register address
//   wr_data           write byte
//   FRW               ready (init done and idle)
//   rd_data/rd_valid  last read byte, one-cycle pulse in DONE of a read
//   CS_n/RD_n/WR_n    RTC strobes, active low
//   AD_sel            0=address phase, 1=data phase
//   AD_out/AD_oe      pad drive value and enable
//   AD_in             pad sample
module rtc_bus_ctrl #(
  parameter int         T_PHASE  = 4,
  parameter logic [7:0] INIT_REG = 8'h02
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic       Mod,
  input  logic [6:0] Dir,
  input  logic [7:0] wr_data,
  output logic       FRW,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_sel,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  input  logic [7:0] AD_in
);

  localparam int CW = (T_PHASE > 2) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] LAST = CW'(T_PHASE - 1);

  typedef enum logic [2:0] {
    INIT0, INIT1, IDLE, ADDR, GAP1, DATA, GAP2, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    dir_q, dir_d;
  logic [7:0]    wd_q, wd_d;
  logic          mod_q, mod_d;
  logic [1:0]    ini_q, ini_d;
  logic [7:0]    rd_d;
  logic          wrap;

  logic       frw_d, rv_d, cs_d, rdn_d, wrn_d, sel_d, oe_d;
  logic [7:0] out_d;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dir_d   = dir_q;
    wd_d    = wd_q;
    mod_d   = mod_q;
    ini_d   = ini_q;
    rd_d    = rd_data;
    unique case (state_q)
      INIT0: begin
        dir_d   = INIT_REG[6:0];
        wd_d    = 8'h10;
        mod_d   = 1'b1;
        ini_d   = 2'd1;
        state_d = ADDR;
      end
      // Stands in for the DONE cycle of the first init write and
      // dispatches the second one.
      INIT1: begin
        wd_d    = 8'h00;
        ini_d   = 2'd2;
        state_d = ADDR;
      end
      IDLE: begin
        if (Acceso) begin
          dir_d   = Dir;
          wd_d    = wr_data;
          mod_d   = Mod;
          ini_d   = 2'd0;
          state_d = ADDR;
        end
      end
      ADDR, GAP1, DATA, GAP2: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          unique case (state_q)
            ADDR:    state_d = GAP1;
            GAP1:    state_d = DATA;
            DATA:    state_d = GAP2;
            default: state_d = (ini_q == 2'd1) ? INIT1 : DONE;
          endcase
        end
        if (state_q == DATA && wrap && !mod_q)
          rd_d = AD_in;
      end
      DONE: begin
        ini_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = INIT0;
    endcase
  end

  // Bus outputs decoded from the next state so they leave flops.
  always_comb begin
    frw_d = (state_d == IDLE);
    rv_d  = (state_d == DONE) && !mod_d;
    cs_d  = 1'b1;
    rdn_d = 1'b1;
    wrn_d = 1'b1;
    sel_d = 1'b0;
    oe_d  = 1'b0;
    out_d = 8'h00;
    unique case (1'b1)
      state_d == ADDR: begin
        cs_d  = 1'b0;
        wrn_d = 1'b0;
        oe_d  = 1'b1;
        out_d = {1'b0, dir_d};
      end
      state_d == DATA: begin
        cs_d  = 1'b0;
        sel_d = 1'b1;
        if (mod_d) begin
          wrn_d = 1'b0;
          oe_d  = 1'b1;
          out_d = wd_d;
        end else begin
          rdn_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= INIT0;
      cnt_q    <= '0;
      dir_q    <= '0;
      wd_q     <= '0;
      mod_q    <= 1'b0;
      ini_q    <= 2'd0;
      rd_data  <= 8'h00;
      FRW      <= 1'b0;
      rd_valid <= 1'b0;
      CS_n     <= 1'b1;
      RD_n     <= 1'b1;
      WR_n     <= 1'b1;
      AD_sel   <= 1'b0;
      AD_out   <= 8'h00;
      AD_oe    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      wd_q     <= wd_d;
      mod_q    <= mod_d;
      ini_q    <= ini_d;
      rd_data  <= rd_d;
      FRW      <= frw_d;
      rd_valid <= rv_d;
      CS_n     <= cs_d;
      RD_n     <= rdn_d;
      WR_n     <= wrn_d;
      AD_sel   <= sel_d;
      AD_out   <= out_d;
      AD_oe    <= oe_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed bench for rtc_bus_ctrl
// (init sequence, write, read, busy strobe, mid-cycle reset).
module tb_rtc_bus_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Acceso;
  logic       Mod;
  logic [6:0] Dir;
  logic [7:0] wr_data;
  logic       FRW;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       AD_sel;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic [7:0] AD_in;

  int checks   = 0;
  int failures = 0;

  rtc_bus_ctrl #(.T_PHASE(4), .INIT_REG(8'h02)) dut (
    .CLK(CLK), .RST(RST), .Acceso(Acceso), .Mod(Mod),
    .Dir(Dir), .wr_data(wr_data), .FRW(FRW),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .AD_sel(AD_sel), .AD_out(AD_out), .AD_oe(AD_oe),
    .AD_in(AD_in)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      chk("rd_wr_excl", 32'(!RD_n && !WR_n), 0);
      chk("rd_oe_excl", 32'(!RD_n && AD_oe), 0);
    end
  end

  // Called #1 after the last edge that samples RST high.
  task automatic wait_init(input string nm);
    int n;
    for (n = 1; n <= 100; n++) begin
      @(posedge CLK); #1;
      if (n == 1) begin
        chk({nm, "_a1_out"}, AD_out, 8'h02);
        chk({nm, "_a1_wr"}, WR_n, 0);
      end
      if (n == 9) begin
        chk({nm, "_d1_out"}, AD_out, 8'h10);
        chk({nm, "_d1_sel"}, AD_sel, 1);
      end
      if (n == 18) chk({nm, "_a2_out"}, AD_out, 8'h02);
      if (n == 26) begin
        chk({nm, "_d2_out"}, AD_out, 8'h00);
        chk({nm, "_d2_wr"}, WR_n, 0);
      end
      if (FRW) break;
    end
    chk({nm, "_frw_cycle"}, n, 35);
  endtask

  // Called #1 after an edge with FRW=1; returns at cycle 18.
  task automatic access(input logic m, input logic [6:0] d,
                        input logic [7:0] wd,
                        input logic [7:0] din,
                        input bit hold, input string nm);
    Acceso = 1'b1; Mod = m; Dir = d; wr_data = wd;
    for (int k = 1; k <= 18; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        Acceso  = hold;
        Mod     = !m;
        Dir     = ~d;
        wr_data = ~wd;
        chk({nm, "_a_frw"}, FRW, 0);
        chk({nm, "_a_cs"}, CS_n, 0);
        chk({nm, "_a_wr"}, WR_n, 0);
        chk({nm, "_a_rd"}, RD_n, 1);
        chk({nm, "_a_sel"}, AD_sel, 0);
        chk({nm, "_a_oe"}, AD_oe, 1);
        chk({nm, "_a_out"}, AD_out, {1'b0, d});
      end
      if (k == 4) chk({nm, "_a4_out"}, AD_out, {1'b0, d});
      if (k == 5) begin
        chk({nm, "_g1_cs"}, CS_n, 1);
        chk({nm, "_g1_oe"}, AD_oe, 0);
      end
      if (k == 9) begin
        AD_in = din;
        chk({nm, "_d_cs"}, CS_n, 0);
        chk({nm, "_d_sel"}, AD_sel, 1);
        chk({nm, "_d_wr"}, WR_n, !m);
        chk({nm, "_d_rd"}, RD_n, m);
        chk({nm, "_d_oe"}, AD_oe, m);
        if (m) chk({nm, "_d_out"}, AD_out, wd);
      end
      if (k == 13) begin
        AD_in = 8'hEE;
        chk({nm, "_g2_cs"}, CS_n, 1);
        if (!m) chk({nm, "_rdata"}, rd_data, din);
      end
      if (k == 16) chk({nm, "_rv_early"}, rd_valid, 0);
      if (k == 17) begin
        chk({nm, "_rv"}, rd_valid, !m);
        chk({nm, "_done_frw"}, FRW, 0);
        chk({nm, "_done_cs"}, CS_n, 1);
      end
      if (k == 18) begin
        chk({nm, "_frw"}, FRW, 1);
        chk({nm, "_rv_end"}, rd_valid, 0);
      end
    end
  endtask

  initial begin
    RST = 1'b1; Acceso = 1'b0; Mod = 1'b0;
    Dir = '0; wr_data = '0; AD_in = 8'hEE;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_frw", FRW, 0);
    chk("rst_cs", CS_n, 1);
    chk("rst_rd", RD_n, 1);
    chk("rst_wr", WR_n, 1);
    chk("rst_sel", AD_sel, 0);
    chk("rst_out", AD_out, 8'h00);
    chk("rst_oe", AD_oe, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_rdata", rd_data, 8'h00);
    RST = 1'b0;
    wait_init("init");

    access(1'b1, 7'h21, 8'h59, 8'h00, 1'b0, "wr21");
    access(1'b0, 7'h43, 8'h00, 8'h07, 1'b0, "rd43");
    access(1'b1, 7'h10, 8'hA5, 8'h00, 1'b0, "wr10");
    chk("rdata_hold", rd_data, 8'h07);
    access(1'b0, 7'h05, 8'h00, 8'h3C, 1'b1, "hold");
    access(1'b1, 7'h7F, 8'hFF, 8'h00, 1'b0, "b2b");
    chk("b2b_rdata", rd_data, 8'h3C);

    Acceso = 1'b1; Mod = 1'b1; Dir = 7'h11; wr_data = 8'h22;
    @(posedge CLK); #1;
    Acceso = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("mid_data_wr", WR_n, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst_cs", CS_n, 1);
    chk("mid_rst_wr", WR_n, 1);
    chk("mid_rst_frw", FRW, 0);
    chk("mid_rst_oe", AD_oe, 0);
    chk("mid_rst_rdata", rd_data, 8'h00);
    RST = 1'b0;
    wait_init("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
